// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: runs one req/ack transaction per access, steers
// store lanes, formats load data and stalls the pipeline until completion.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        fault_o,
  output logic        bus_err_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    f3_r;
  logic [1:0]    off_r;
  logic          access_s;
  logic          fault_s;
  logic          expire_s;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   store_lanes = {4{w[7:0]}};
      2'b01:   store_lanes = {2{w[15:0]}};
      default: store_lanes = w;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  load_fmt = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_fmt = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_fmt = w;
      3'b100:  load_fmt = {24'h000000, sh[7:0]};
      3'b101:  load_fmt = {16'h0000, sh[15:0]};
      default: load_fmt = 32'h00000000;
    endcase
  endfunction

  assign access_s = valid_i & (mem_read_i | mem_write_i);

  // Decode illegal / misaligned accesses from the raw EX/MEM inputs.
  always_comb begin
    fault_s = 1'b0;
    if (access_s) begin
      if (mem_read_i && mem_write_i) begin
        fault_s = 1'b1;
      end else if (mem_read_i) begin
        case (funct3_i)
          3'b000, 3'b100: fault_s = 1'b0;
          3'b001, 3'b101: fault_s = addr_i[0];
          3'b010:         fault_s = (addr_i[1:0] != 2'b00);
          default:        fault_s = 1'b1;
        endcase
      end else begin
        case (funct3_i)
          3'b000:  fault_s = 1'b0;
          3'b001:  fault_s = addr_i[0];
          3'b010:  fault_s = (addr_i[1:0] != 2'b00);
          default: fault_s = 1'b1;
        endcase
      end
    end else begin
      fault_s = 1'b0;
    end
  end

  // Timeout expiry for the current REQ cycle; TIMEOUT of zero never expires.
  always_comb begin
    expire_s = 1'b0;
    if (TIMEOUT != 0) begin
      expire_s = (cnt_r == TO_LAST);
    end else begin
      expire_s = 1'b0;
    end
  end

  assign fault_o = (state_r == ST_IDLE) & fault_s;
  assign stall_o = ((state_r == ST_IDLE) & access_s & ~fault_s) | (state_r == ST_REQ);

  // Transaction FSM with registered memory-side and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h00000000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h00000000;
      done_o     <= 1'b0;
      bus_err_o  <= 1'b0;
      rdata_o    <= 32'h00000000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          cnt_r     <= '0;
          if (access_s && !fault_s) begin
            state_r    <= ST_REQ;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_i;
            dmem_addr  <= {addr_i[31:2], 2'b00};
            dmem_be    <= mem_write_i ? store_be(funct3_i, addr_i[1:0]) : 4'b1111;
            dmem_wdata <= mem_write_i ? store_lanes(funct3_i, wdata_i) : 32'h00000000;
            f3_r       <= funct3_i;
            off_r      <= addr_i[1:0];
          end
        end
        ST_REQ: begin
          // An ack in the expiry cycle still completes normally.
          if (dmem_ack) begin
            state_r   <= ST_DONE;
            dmem_req  <= 1'b0;
            done_o    <= 1'b1;
            bus_err_o <= 1'b0;
            rdata_o   <= dmem_we ? 32'h00000000 : load_fmt(f3_r, off_r, dmem_rdata);
          end else if (expire_s) begin
            state_r   <= ST_DONE;
            dmem_req  <= 1'b0;
            done_o    <= 1'b1;
            bus_err_o <= 1'b1;
            rdata_o   <= 32'h00000000;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          cnt_r     <= '0;
        end
        default: begin
          state_r   <= ST_IDLE;
          dmem_req  <= 1'b0;
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed, table-driven bench for lsu_mem_ctrl (TIMEOUT=4) with hand-written
// reset-abort and idle-input sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, done_o, fault_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .fault_o(fault_o),
    .bus_err_o(bus_err_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          wait_n;
    logic        give_ack;
    logic        efault;
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [31:0] erdata;
    logic        eerr;
    int          ereq;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    int    req_cycles;
    logic  got_done;
    logic  unstable;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = v.rd; mem_write_i = v.wr;
    funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
    #1;
    chk({p, "_fault"}, {31'd0, fault_o}, {31'd0, v.efault});
    chk({p, "_stall_t"}, {31'd0, stall_o}, {31'd0, ~v.efault});
    if (v.efault) begin
      @(negedge clk);
      chk({p, "_noreq"}, {31'd0, dmem_req}, 32'd0);
      chk({p, "_fault_hold"}, {31'd0, fault_o}, 32'd1);
      valid_i = 1'b0;
    end else begin
      @(negedge clk);
      valid_i = 1'b0;
      chk({p, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({p, "_we"}, {31'd0, dmem_we}, {31'd0, v.wr});
      chk({p, "_be"}, {28'd0, dmem_be}, {28'd0, v.ebe});
      chk({p, "_addr"}, dmem_addr, v.eaddr);
      if (v.wr) chk({p, "_wdata"}, dmem_wdata, v.ewdata);
      chk({p, "_stall_req"}, {31'd0, stall_o}, 32'd1);
      req_cycles = 0; got_done = 1'b0; unstable = 1'b0;
      for (int k = 0; k < 20 && !got_done; k++) begin
        if (done_o) begin
          got_done = 1'b1;
        end else begin
          if (dmem_req) begin
            req_cycles++;
            if (dmem_be !== v.ebe || dmem_addr !== v.eaddr || stall_o !== 1'b1) unstable = 1'b1;
          end
          dmem_ack = v.give_ack && (req_cycles == v.wait_n + 1);
          dmem_rdata = v.mrdata;
          @(negedge clk);
        end
      end
      dmem_ack = 1'b0;
      chk({p, "_done"}, {31'd0, got_done}, 32'd1);
      chk({p, "_reqcycles"}, req_cycles, v.ereq);
      chk({p, "_stable"}, {31'd0, unstable}, 32'd0);
      chk({p, "_rdata"}, rdata_o, v.erdata);
      chk({p, "_buserr"}, {31'd0, bus_err_o}, {31'd0, v.eerr});
      chk({p, "_stall_done"}, {31'd0, stall_o}, 32'd0);
      chk({p, "_req_done"}, {31'd0, dmem_req}, 32'd0);
      @(negedge clk);
      chk({p, "_done_pulse"}, {31'd0, done_o}, 32'd0);
      chk({p, "_err_clr"}, {31'd0, bus_err_o}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rd    wr    f3      addr          wdata         mrdata        wt ack   flt   be       eaddr         ewdata        erdata        err  req
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,       32'hDEADBEEF, 0, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'hDEADBEEF, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,       32'h80112233, 0, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'hFFFFFF80, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,       32'h80112233, 1, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'h00000080, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,       32'h80112233, 0, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'hFFFF8011, 1'b0, 1};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h00000102, 32'h0,       32'h80112233, 0, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'h00008011, 1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0,       32'h80112233, 2, 1'b1, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'h00000022, 1'b0, 3};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h00000201, 32'h000000AB, 32'h12345678, 0, 1'b1, 1'b0, 4'b0010, 32'h00000200, 32'hABABABAB, 32'h00000000, 1'b0, 1};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h00000202, 32'h0000CAFE, 32'h12345678, 0, 1'b1, 1'b0, 4'b1100, 32'h00000200, 32'hCAFECAFE, 32'h00000000, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h00000204, 32'h01234567, 32'h12345678, 1, 1'b1, 1'b0, 4'b1111, 32'h00000204, 32'h01234567, 32'h00000000, 1'b0, 2};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h00000100, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h00000100, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h00000200, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h00000201, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h00000103, 32'h0,       32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b0, 0};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h00000108, 32'h0,       32'h0,        0, 1'b0, 1'b0, 4'b1111, 32'h00000108, 32'h0,        32'h00000000, 1'b1, 4};
    vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h0000010C, 32'h0,       32'h5A5A0001, 3, 1'b1, 1'b0, 4'b1111, 32'h0000010C, 32'h0,        32'h5A5A0001, 1'b0, 4};

    reset = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, bus_err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);

    // Not valid: misaligned read request must neither fault nor stall.
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h00000103;
    #1;
    chk("novalid_fault", {31'd0, fault_o}, 32'd0);
    chk("novalid_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("novalid_req", {31'd0, dmem_req}, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset during REQ with ack pending aborts; later acks are ignored.
    @(negedge clk);
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
    funct3_i = 3'b010; addr_i = 32'h00000300;
    @(negedge clk);
    valid_i = 1'b0;
    chk("rreq_req", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    @(negedge clk);
    chk("rreq_req_off", {31'd0, dmem_req}, 32'd0);
    chk("rreq_stall", {31'd0, stall_o}, 32'd0);
    chk("rreq_done", {31'd0, done_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rreq_ack_ign_done", {31'd0, done_o}, 32'd0);
    chk("rreq_ack_ign_req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    chk("rreq_ack_ign_done2", {31'd0, done_o}, 32'd0);
    chk("rreq_rdata", rdata_o, 32'd0);
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
